clk_div_prog: RTL and testbench

Programmable integer clock divider. It generates a 50 %-duty output clock at clk/N for any N from 2 to 2^WIDTH−1, odd or even, and supports enable/disable and runtime divisor changes without glitches or runt pulses. It also produces a single-cycle period-start tick and status flags. It sits in the clock-generation area and feeds downstream peripheral clocks and strobes from the system clock.

---
 rtl/clk_div_prog.sv | 183 ++++++++++++++++++
 tb/tb_clk_div_prog.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Programmable integer clock divider. Produces a 50 %-duty clock at clk/N for
// any N in 2..2^WIDTH-1 (odd or even), with glitch-free enable/disable and
// divisor changes that only take effect at a period boundary.
//
// Parameters:
//   WIDTH      divisor and period-counter width
//   DIV_RESET  divisor in force after reset (2..2^WIDTH-1)
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   en        in   run request, sampled on clk rising edge
//   div_load  in   one-cycle strobe loading div_in
//   div_in    in   requested divisor N
//   clk_out   out  divided clock (OR of a rising-edge and a falling-edge flop)
//   tick      out  high in the first clk cycle of every output period
//   cur_div   out  divisor governing the current period
//   pending   out  a loaded divisor waits for the next period boundary
//   load_err  out  one-cycle pulse after a load of div_in < 2
//   running   out  divider is producing periods
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             pending,
    output logic             load_err,
    output logic             running
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_RESET);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cur_div_r;
    logic [WIDTH-1:0] shadow_r;
    logic             pending_r;
    logic             load_err_r;
    logic             tick_r;
    logic             running_r;
    logic             hi_pos_r;   // high for cnt 0..N/2-1 (even) or 0..(N-3)/2 (odd)
    logic             hi_neg_r;   // hi_pos_r delayed half a clk, only for odd N

    logic             valid_load_s;
    logic             bad_load_s;
    logic             wrap_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] next_div_s;
    logic             hi_next_s;

    // Next-period divisor selection, wrap detection and high-phase compare.
    always_comb begin
        valid_load_s = div_load && (div_in >= DIV_MIN);
        bad_load_s   = div_load && (div_in < DIV_MIN);
        // cur_div_r >= 2 always, so the subtraction never underflows and
        // N = 2^WIDTH-1 compares against 2^WIDTH-2 without overflow.
        wrap_s       = (cnt_r == (cur_div_r - ONE));
        cnt_inc_s    = cnt_r + ONE;
        // A load coinciding with a boundary beats any older shadow value.
        if (valid_load_s) begin
            next_div_s = div_in;
        end else if (pending_r) begin
            next_div_s = shadow_r;
        end else begin
            next_div_s = cur_div_r;
        end
        // Counter value entering the next cycle lies in the high phase.
        hi_next_s = (cnt_inc_s < (cur_div_r >> 1));
    end

    // Run/stop state machine, period counter, divisor registers and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_STOPPED;
            cnt_r      <= '0;
            cur_div_r  <= DIV_RST;
            shadow_r   <= DIV_RST;
            pending_r  <= 1'b0;
            load_err_r <= 1'b0;
            tick_r     <= 1'b0;
            running_r  <= 1'b0;
            hi_pos_r   <= 1'b0;
        end else begin
            load_err_r <= bad_load_s;
            case (state_r)
                ST_STOPPED: begin
                    cnt_r     <= '0;
                    // Nothing can be pending here; loads apply directly.
                    cur_div_r <= next_div_s;
                    pending_r <= 1'b0;
                    if (en) begin
                        // Start edge is a boundary: period begins high.
                        state_r   <= ST_RUNNING;
                        running_r <= 1'b1;
                        tick_r    <= 1'b1;
                        hi_pos_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_STOPPED;
                        running_r <= 1'b0;
                        tick_r    <= 1'b0;
                        hi_pos_r  <= 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (wrap_s) begin
                        cnt_r     <= '0;
                        cur_div_r <= next_div_s;
                        pending_r <= 1'b0;
                        if (en) begin
                            state_r   <= ST_RUNNING;
                            running_r <= 1'b1;
                            tick_r    <= 1'b1;
                            hi_pos_r  <= 1'b1;
                        end else begin
                            // Stop only at the wrap so no period is cut short.
                            state_r   <= ST_STOPPED;
                            running_r <= 1'b0;
                            tick_r    <= 1'b0;
                            hi_pos_r  <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_RUNNING;
                        cnt_r     <= cnt_inc_s;
                        running_r <= 1'b1;
                        tick_r    <= 1'b0;
                        hi_pos_r  <= hi_next_s;
                        if (valid_load_s) begin
                            shadow_r  <= div_in;
                            pending_r <= 1'b1;
                        end else begin
                            shadow_r  <= shadow_r;
                            pending_r <= pending_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_STOPPED;
                    cnt_r     <= '0;
                    pending_r <= 1'b0;
                    running_r <= 1'b0;
                    tick_r    <= 1'b0;
                    hi_pos_r  <= 1'b0;
                end
            endcase
        end
    end

    // Half-cycle extension for odd divisors: stretches the high phase to the
    // falling edge in the middle of cnt = (N-1)/2; held low for even N.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            hi_neg_r <= 1'b0;
        end else begin
            hi_neg_r <= hi_pos_r & cur_div_r[0];
        end
    end

    assign clk_out  = hi_pos_r | hi_neg_r;
    assign tick     = tick_r;
    assign cur_div  = cur_div_r;
    assign pending  = pending_r;
    assign load_err = load_err_r;
    assign running  = running_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Self-checking bench for clk_div_prog. Time is indexed in half-clk samples:
// hc = 2E+1 is the sample just after rising edge E (time 10E+6), hc = 2E+2
// the sample just after the following falling edge. Stimulus drives inputs at
// falling edges and pushes expected output values tagged with their hc into a
// scoreboard queue; an independent monitor samples every half cycle and
// compares all entries due at that sample.
//
// Expected clk_out for a period of N starting at edge E: high for the N half
// samples hc = 2E+1 .. 2E+N, low for the following N.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int K_CLK  = 0;
    localparam int K_TICK = 1;
    localparam int K_RUN  = 2;
    localparam int K_PEND = 3;
    localparam int K_CDIV = 4;
    localparam int K_LERR = 5;

    typedef struct {
        int    hc;
        int    kind;
        int    val;
        string nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_load;
    logic [7:0] div_in;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;
    logic       pending;
    logic       load_err;
    logic       running;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    clk_div_prog #(.WIDTH(8), .DIV_RESET(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_load (div_load),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .tick     (tick),
        .cur_div  (cur_div),
        .pending  (pending),
        .load_err (load_err),
        .running  (running)
    );

    always #5 clk = ~clk;

    function automatic int actual(int kind);
        case (kind)
            K_CLK:   return int'(clk_out);
            K_TICK:  return int'(tick);
            K_RUN:   return int'(running);
            K_PEND:  return int'(pending);
            K_CDIV:  return int'(cur_div);
            K_LERR:  return int'(load_err);
            default: return -1;
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            K_CLK:   return "clk_out";
            K_TICK:  return "tick";
            K_RUN:   return "running";
            K_PEND:  return "pending";
            K_CDIV:  return "cur_div";
            K_LERR:  return "load_err";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int hc, input int kind, input int val, input string tag);
        exp_t e;
        e.hc   = hc;
        e.kind = kind;
        e.val  = val;
        e.nm   = {kname(kind), " ", tag};
        q.push_back(e);
    endtask

    // Checks at the rising-edge sample of cycle e.
    task automatic push_cyc(input int e, input int kind, input int val, input string tag);
        push(2 * e + 1, kind, val, tag);
    endtask

    // Full expected period of divisor n starting at boundary edge e.
    task automatic exp_period(input int e, input int n);
        string tag;
        tag = $sformatf("period N=%0d @%0d", n, e);
        for (int h = 0; h < 2 * n; h++) begin
            push(2 * e + 1 + h, K_CLK, (h < n) ? 1 : 0, tag);
        end
        push_cyc(e, K_TICK, 1, tag);
        for (int k = 1; k < n; k++) begin
            push_cyc(e + k, K_TICK, 0, tag);
        end
        push_cyc(e, K_RUN, 1, tag);
        push_cyc(e, K_CDIV, n, tag);
        push_cyc(e, K_PEND, 0, tag);
    endtask

    // Wait for the falling edge preceding rising edge e (time 10e).
    task automatic goto(input int e);
        while ($time < 64'(10 * e)) @(negedge clk);
    endtask

    task automatic load(input int e, input int val);
        goto(e);
        div_load = 1'b1;
        div_in   = 8'(val);
        goto(e + 1);
        div_load = 1'b0;
    endtask

    // Monitor: compares every scoreboard entry due at the current half sample.
    always begin
        int hc;
        int act;
        @(posedge clk or negedge clk);
        #1;
        hc = int'(($time - 64'd1) / 64'd5);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].hc == hc) begin
                act = actual(q[i].kind);
                checks++;
                if (act != q[i].val) begin
                    errors++;
                    $display("FAIL %s hc=%0d got=%0d expected=%0d", q[i].nm, hc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    // Watchdog in case the stimulus sequence never completes.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = 8'd0;
        #1 rst   = 1'b0;

        // Reset values, and idle after release.
        for (int h = 1; h <= 3; h++) begin
            push(h, K_CLK, 0, "reset");
            push(h, K_RUN, 0, "reset");
            push(h, K_TICK, 0, "reset");
            push(h, K_PEND, 0, "reset");
            push(h, K_LERR, 0, "reset");
            push(h, K_CDIV, 2, "reset");
        end
        goto(1);
        rst = 1'b1;

        // Start at N=2: running and tick in the cycle after edge 2.
        goto(2);
        en = 1'b1;
        exp_period(2, 2);
        exp_period(4, 2);
        exp_period(6, 2);

        // Loads on wrap edges apply immediately.
        exp_period(8, 5);
        exp_period(13, 5);
        load(8, 5);
        exp_period(18, 3);
        exp_period(21, 3);
        load(18, 3);
        exp_period(24, 255);
        load(24, 255);

        // Mid-period loads at N=255; second load overwrites the shadow.
        push_cyc(100, K_PEND, 1, "load 9 mid");
        push_cyc(101, K_CDIV, 255, "load 9 mid");
        load(100, 9);
        push_cyc(150, K_PEND, 1, "load 4 overwrite");
        push_cyc(278, K_PEND, 1, "load 4 overwrite");
        push_cyc(278, K_CDIV, 255, "load 4 overwrite");
        exp_period(279, 4);
        exp_period(283, 4);
        load(150, 4);

        // N=4, load 7 at cnt=1: current period untouched, next one is 7.
        push_cyc(285, K_PEND, 1, "load 7 mid");
        push_cyc(286, K_CDIV, 4, "load 7 mid");
        exp_period(287, 7);
        exp_period(294, 7);
        load(285, 7);

        // Illegal loads 0 and 1: load_err pulses, nothing else changes.
        push_cyc(295, K_LERR, 1, "bad load 0");
        push_cyc(296, K_LERR, 0, "bad load 0");
        push_cyc(297, K_LERR, 1, "bad load 1");
        push_cyc(298, K_LERR, 0, "bad load 1");
        push_cyc(298, K_PEND, 0, "bad loads");
        push_cyc(298, K_CDIV, 7, "bad loads");
        exp_period(301, 7);
        load(295, 0);
        load(297, 1);

        // Switch to N=6, then drop en at cnt=2: period completes, then stop.
        push_cyc(305, K_PEND, 1, "load 6 mid");
        push_cyc(307, K_CDIV, 7, "load 6 mid");
        exp_period(308, 6);
        load(305, 6);
        goto(311);
        en = 1'b0;
        push_cyc(313, K_RUN, 1, "stop last cycle");
        for (int e = 314; e <= 319; e++) begin
            push(2 * e + 1, K_CLK, 0, "stopped");
            push(2 * e + 2, K_CLK, 0, "stopped");
            push_cyc(e, K_RUN, 0, "stopped");
            push_cyc(e, K_TICK, 0, "stopped");
        end

        // Re-raise en: a full period starts at once.
        goto(320);
        en = 1'b1;
        exp_period(320, 6);

        // Async reset in the high phase of a period with a load pending.
        for (int h = 653; h <= 657; h++) begin
            push(h, K_CLK, 1, "pre-reset high");
        end
        push_cyc(326, K_TICK, 1, "pre-reset");
        push_cyc(327, K_PEND, 1, "pre-reset load 9");
        push(658, K_CLK, 0, "async reset");
        push(658, K_PEND, 0, "async reset");
        push(658, K_RUN, 0, "async reset");
        push(658, K_TICK, 0, "async reset");
        load(327, 9);
        #7;
        rst = 1'b0;
        en  = 1'b0;

        goto(330);
        checks++;
        if (cur_div !== 8'd2) begin
            errors++;
            $display("FAIL in-reset cur_div got=%0d expected=2", cur_div);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL in-reset pending got=%0b expected=0", pending);
        end
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL in-reset running got=%0b expected=0", running);
        end
        checks++;
        if (clk_out !== 1'b0) begin
            errors++;
            $display("FAIL in-reset clk_out got=%0b expected=0", clk_out);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL in-reset tick got=%0b expected=0", tick);
        end
        rst = 1'b1;
        push_cyc(330, K_CDIV, 2, "after reset");
        push_cyc(330, K_PEND, 0, "after reset");
        push_cyc(330, K_RUN, 0, "after reset");
        push_cyc(330, K_CLK, 0, "after reset");

        // Restart: reset divisor governs, the discarded 9 never appears.
        goto(332);
        en = 1'b1;
        exp_period(332, 2);
        exp_period(334, 2);

        goto(345);
        // Anything still queued was never compared.
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked %s hc=%0d expected=%0d", q[0].nm, q[0].hc, q[0].val);
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
